// File: rtl/vga_fb_arbiter.sv
// Shares one character RAM between VGA cell prefetch and a req/ack status writer.
// Define VBLANK_WR_ONLY_EN to restrict writer grants to vertical blanking.
module vga_fb_arbiter #(
  parameter int COLS   = 80,
  parameter int ROWS   = 60,
  parameter int ADDR_W = 13,
  parameter int DATA_W = 16
) (
  input  logic              pixel_clk,
  input  logic              rst,
  input  logic [9:0]        counter_x,
  input  logic [8:0]        counter_y,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic              wr_oob,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] pix_word,
  output logic              pix_word_valid
);

  localparam logic [ADDR_W:0] CELLS = (ADDR_W+1)'(COLS * ROWS);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    HOLD
  } wrState_t;

  wrState_t          wrState;
  logic [2:0]        phase;
  logic [9:0]        tx;
  logic [9:0]        ty;
  logic              tgtValid;
  logic              scanClaim;
  logic              vblankOk;
  logic              wrGo;
  logic              inRange;
  logic [ADDR_W-1:0] scanAddr;
  logic [DATA_W-1:0] nextWord;
  logic              nextValid;

  // Target is the cell whose first pixel follows the current cell.
  always_comb begin
    phase = counter_x[2:0];
    tx    = counter_x + 10'd4;
    ty    = {1'b0, counter_y};
    if (counter_x >= 10'd764) begin
      tx = counter_x - 10'd764;
      ty = {1'b0, counter_y} + 10'd1;
    end
    tgtValid  = (tx < 10'd640) && (ty < 10'd480);
    scanClaim = (phase == 3'd4) && tgtValid;
    scanAddr  = ADDR_W'(ty[8:3]) * ADDR_W'(COLS)
              + ADDR_W'(tx[9:3]);
    inRange   = {1'b0, wr_addr} < CELLS;
`ifdef VBLANK_WR_ONLY_EN
    vblankOk  = counter_y >= 9'd480;
`else
    vblankOk  = 1'b1;
`endif
    wrGo = (wrState == IDLE) && wr_req
        && !scanClaim && vblankOk;
  end

  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      wrState        <= IDLE;
      ram_addr       <= '0;
      ram_we         <= 1'b0;
      ram_wdata      <= '0;
      wr_ack         <= 1'b0;
      wr_oob         <= 1'b0;
      pix_word       <= '0;
      pix_word_valid <= 1'b0;
      nextWord       <= '0;
      nextValid      <= 1'b0;
    end else begin
      ram_we <= 1'b0;
      wr_ack <= 1'b0;

      if (phase == 3'd4) nextValid <= tgtValid;
      if (phase == 3'd6) nextWord <= ram_rdata;
      if (phase == 3'd7) begin
        pix_word       <= nextWord;
        pix_word_valid <= nextValid;
      end

      if (scanClaim) ram_addr <= scanAddr;

      unique case (wrState)
        IDLE: begin
          if (wrGo) begin
            wrState   <= GRANT;
            ram_addr  <= wr_addr;
            ram_wdata <= wr_data;
            ram_we    <= inRange;
            wr_ack    <= 1'b1;
            if (!inRange) wr_oob <= 1'b1;
          end
        end
        GRANT:   wrState <= HOLD;
        HOLD:    wrState <= IDLE;
        default: wrState <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter: table of pixel-word checks
// plus hand sequences for prefetch timing and writer arbitration.
module tb_vga_fb_arbiter;

  logic        pixel_clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  counter_x = '0;
  logic [8:0]  counter_y = '0;
  logic        wr_req = 1'b0;
  logic [12:0] wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic        wr_ack;
  logic        wr_oob;
  logic [12:0] ram_addr;
  logic        ram_we;
  logic [15:0] ram_wdata;
  logic [15:0] ram_rdata;
  logic [15:0] pix_word;
  logic        pix_word_valid;

  logic [15:0] mem [0:8191];

  int checks = 0;
  int errors = 0;

  vga_fb_arbiter dut (
    .pixel_clk(pixel_clk),
    .rst(rst),
    .counter_x(counter_x),
    .counter_y(counter_y),
    .wr_req(wr_req),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .wr_ack(wr_ack),
    .wr_oob(wr_oob),
    .ram_addr(ram_addr),
    .ram_we(ram_we),
    .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata),
    .pix_word(pix_word),
    .pix_word_valid(pix_word_valid)
  );

  always #5 pixel_clk = ~pixel_clk;

  always @(posedge pixel_clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  initial begin
    #600000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge pixel_clk);
    #1;
    if (counter_x == 10'd767) begin
      counter_x = '0;
      counter_y = (counter_y == 9'd524) ? '0 : counter_y + 9'd1;
    end else begin
      counter_x = counter_x + 10'd1;
    end
  endtask

  task automatic setPos(input int x, input int y);
    counter_x = 10'(x);
    counter_y = 9'(y);
  endtask

  task automatic waitAck(input string name, output bit got);
    got = 0;
    for (int k = 0; k < 12 && !got; k++) begin
      step();
      if (wr_ack) got = 1;
    end
    if (!got) begin
      errors++;
      checks++;
      $display("FAIL %s no wr_ack within budget", name);
    end
  endtask

  typedef struct {
    int          x;
    int          y;
    logic [15:0] word;
    bit          chkWord;
    logic        valid;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int lin;
    int acks;
    int firstAck;
    int lastAck;
    bit got;

    vecs[0] = '{16, 8, 16'd82, 1, 1'b1};
    vecs[1] = '{23, 8, 16'd82, 1, 1'b1};
    vecs[2] = '{0, 8, 16'd80, 1, 1'b1};
    vecs[3] = '{632, 0, 16'd79, 1, 1'b1};
    vecs[4] = '{639, 479, 16'd4799, 1, 1'b1};
    vecs[5] = '{100, 300, 16'd2972, 1, 1'b1};
    vecs[6] = '{311, 200, 16'd2038, 1, 1'b1};
    vecs[7] = '{8, 0, 16'd1, 1, 1'b1};
    vecs[8] = '{640, 10, 16'd0, 0, 1'b0};
    vecs[9] = '{0, 480, 16'd0, 0, 1'b0};

    for (int i = 0; i < 8192; i++) mem[i] = 16'(i);

    step();
    step();
    chk("rst_ram_addr", 32'(ram_addr), 0);
    chk("rst_ram_we", 32'(ram_we), 0);
    chk("rst_ram_wdata", 32'(ram_wdata), 0);
    chk("rst_wr_ack", 32'(wr_ack), 0);
    chk("rst_wr_oob", 32'(wr_oob), 0);
    chk("rst_pix_word", 32'(pix_word), 0);
    chk("rst_pix_valid", 32'(pix_word_valid), 0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      lin = vecs[i].y * 768 + vecs[i].x - 24;
      if (lin < 0) lin += 525 * 768;
      setPos(lin % 768, lin / 768);
      repeat (24) step();
      chk($sformatf("vec%0d_valid", i),
          32'(pix_word_valid), 32'(vecs[i].valid));
      if (vecs[i].chkWord)
        chk($sformatf("vec%0d_word", i),
            32'(pix_word), 32'(vecs[i].word));
    end

    setPos(4, 8);
    repeat (9) step();
    chk("fetch_addr_x13", 32'(ram_addr), 82);
    chk("fetch_we_x13", 32'(ram_we), 0);

    setPos(760, 7);
    repeat (5) step();
    chk("wrap_addr_x765", 32'(ram_addr), 80);

`ifdef VBLANK_WR_ONLY_EN
    setPos(700, 100);
    wr_addr = 13'd10;
    wr_data = 16'h7777;
    wr_req  = 1'b1;
    acks = 0;
    repeat (2000) begin
      step();
      if (wr_ack) acks++;
    end
    chk("vbl_no_ack_visible", 32'(acks), 0);
    setPos(760, 479);
    waitAck("vbl_ack", got);
    wr_req = 1'b0;
    if (got) begin
      chk("vbl_ack_y", 32'(counter_y), 480);
      chk("vbl_ack_x", 32'(counter_x), 1);
      chk("vbl_ack_we", 32'(ram_we), 1);
    end
`else
    setPos(96, 50);
    repeat (4) step();
    wr_addr = 13'd1000;
    wr_data = 16'hBEEF;
    wr_req  = 1'b1;
    step();
    chk("col_p5_we", 32'(ram_we), 0);
    chk("col_p5_ack", 32'(wr_ack), 0);
    chk("col_p5_addr", 32'(ram_addr), 493);
    step();
    chk("col_p6_we", 32'(ram_we), 1);
    chk("col_p6_ack", 32'(wr_ack), 1);
    chk("col_p6_addr", 32'(ram_addr), 1000);
    chk("col_p6_wdata", 32'(ram_wdata), 32'hBEEF);
    wr_req = 1'b0;
    step();
    chk("col_p7_we", 32'(ram_we), 0);
    chk("col_p7_ack", 32'(wr_ack), 0);
    step();
    chk("col_pix_word", 32'(pix_word), 493);
    chk("col_pix_valid", 32'(pix_word_valid), 1);
    chk("col_mem_written", 32'(mem[1000]), 32'hBEEF);
    chk("col_no_oob", 32'(wr_oob), 0);

    setPos(696, 100);
    repeat (4) step();
    wr_addr = 13'd3000;
    wr_data = 16'h5555;
    wr_req  = 1'b1;
    acks = 0;
    firstAck = -1;
    lastAck = -1;
    for (int k = 0; k < 12; k++) begin
      if (k == 9) wr_req = 1'b0;
      step();
      if (wr_ack) begin
        acks++;
        if (firstAck < 0) firstAck = int'(counter_x);
        lastAck = int'(counter_x);
      end
    end
    chk("b2b_ack_count", 32'(acks), 3);
    chk("b2b_first_ack", 32'(firstAck), 701);
    chk("b2b_last_ack", 32'(lastAck), 707);

    setPos(700, 200);
    wr_addr = 13'd4800;
    wr_data = 16'hAAAA;
    wr_req  = 1'b1;
    waitAck("oob_ack", got);
    wr_req = 1'b0;
    if (got) begin
      chk("oob_we", 32'(ram_we), 0);
      chk("oob_flag", 32'(wr_oob), 1);
    end
    repeat (6) step();
    chk("oob_sticky", 32'(wr_oob), 1);
    chk("oob_mem_untouched", 32'(mem[4800]), 4800);

    setPos(700, 210);
    wr_addr = 13'd2000;
    wr_data = 16'h1234;
    wr_req  = 1'b1;
    waitAck("rstg_ack", got);
    if (got) begin
      chk("rstg_we_before", 32'(ram_we), 1);
      rst = 1'b1;
      #1;
      chk("rstg_we", 32'(ram_we), 0);
      chk("rstg_ack", 32'(wr_ack), 0);
      chk("rstg_pix_word", 32'(pix_word), 0);
      chk("rstg_oob_clr", 32'(wr_oob), 0);
    end
    wr_req = 1'b0;
    step();
    chk("rstg_mem_aborted", 32'(mem[2000]), 2000);
    rst = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
